// File: rtl/keypad_hex_scanner.sv
// 4x4 hex keypad scanner: row strobe, column sync, full-scan debounce, valid/ack key handshake
// and an eight-key DIGITS/EN history. Define KEYPAD_FIFO_EN for a 4-entry key FIFO in front of the handshake.
module keypad_hex_scanner #(
    parameter logic [15:0] SCAN_DIV       = 16'h8fff,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  KYPD_COL,
    output logic [3:0]  KYPD_ROW,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_VALID,
    input  logic        KEY_ACK,
    output logic        KEY_HELD,
    output logic        KEY_OVERRUN,
    output logic [31:0] DIGITS,
    output logic [7:0]  EN
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    typedef enum logic {IDLE, HELD} state_t;

    logic [3:0]    col_meta, col_sync;
    logic          run_q;
    logic [1:0]    row;
    logic [DW-1:0] dwell;
    logic [11:0]   scan_lo;
    logic          last_dwell, scan_done;
    logic [15:0]   scan_low;
    logic [4:0]    n_low;
    logic [3:0]    hit_idx;
    logic [3:0]    scan_code;
    logic          is_none, is_single;

    state_t        state_q, state_n;
    logic [CW-1:0] deb_q, deb_n;
    logic [3:0]    last_q, last_n;
    logic          accept;

    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:  key_map = 4'h1;
            4'd1:  key_map = 4'h2;
            4'd2:  key_map = 4'h3;
            4'd3:  key_map = 4'hA;
            4'd4:  key_map = 4'h4;
            4'd5:  key_map = 4'h5;
            4'd6:  key_map = 4'h6;
            4'd7:  key_map = 4'hB;
            4'd8:  key_map = 4'h7;
            4'd9:  key_map = 4'h8;
            4'd10: key_map = 4'h9;
            4'd11: key_map = 4'hC;
            4'd12: key_map = 4'h0;
            4'd13: key_map = 4'hF;
            4'd14: key_map = 4'hE;
            default: key_map = 4'hD;
        endcase
    endfunction

    assign last_dwell = run_q && (dwell == SCAN_DIV);
    assign scan_done  = last_dwell && (row == 2'd3);

    // Row strobe lags reset release by one cycle so every row dwells a full SCAN_DIV+1 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta <= 4'hf;
            col_sync <= 4'hf;
            run_q    <= 1'b0;
            row      <= 2'd0;
            dwell    <= '0;
            scan_lo  <= '1;
            KYPD_ROW <= 4'hf;
        end else begin
            col_meta <= KYPD_COL;
            col_sync <= col_meta;
            if (!run_q) begin
                run_q    <= 1'b1;
                KYPD_ROW <= 4'b1110;
            end else if (last_dwell) begin
                dwell    <= '0;
                row      <= row + 2'd1;
                KYPD_ROW <= ~(4'b0001 << 2'(row + 2'd1));
                case (row)
                    2'd0:    scan_lo[3:0]  <= col_sync;
                    2'd1:    scan_lo[7:4]  <= col_sync;
                    2'd2:    scan_lo[11:8] <= col_sync;
                    default: ;
                endcase
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // Classify the completed scan; row 3 comes straight from the synchronizer.
    always_comb begin
        scan_low = ~{col_sync, scan_lo};
        n_low    = 5'd0;
        hit_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (scan_low[i]) begin
                n_low   = n_low + 5'd1;
                hit_idx = 4'(i);
            end
        end
        is_none   = (n_low == 5'd0);
        is_single = (n_low == 5'd1);
        scan_code = key_map(hit_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            deb_q    <= '0;
            last_q   <= 4'd0;
            KEY_HELD <= 1'b0;
            DIGITS   <= 32'd0;
            EN       <= 8'd0;
        end else begin
            state_q  <= state_n;
            deb_q    <= deb_n;
            last_q   <= last_n;
            KEY_HELD <= (state_n == HELD);
            if (accept) begin
                DIGITS <= {DIGITS[27:0], last_n};
                EN     <= {EN[6:0], 1'b1};
            end
        end
    end

    always_comb begin
        state_n = state_q;
        deb_n   = deb_q;
        last_n  = last_q;
        accept  = 1'b0;
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (is_single) begin
                        if ((deb_q != '0) && (scan_code == last_q)) deb_n = deb_q + CW'(1);
                        else                                        deb_n = CW'(1);
                        last_n = scan_code;
                        if (deb_n == CW'(DEBOUNCE_SCANS)) begin
                            accept  = 1'b1;
                            state_n = HELD;
                            deb_n   = '0;
                        end
                    end else begin
                        deb_n = '0;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        deb_n = deb_q + CW'(1);
                        if (deb_n == CW'(DEBOUNCE_SCANS)) begin
                            state_n = IDLE;
                            deb_n   = '0;
                        end
                    end else begin
                        deb_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic [3:0] fifo_mem [4];
    logic [1:0] rd_q, wr_q, rd_n;
    logic [2:0] cnt_q, cnt_n;
    logic       pop, do_push, ovr_n;
    logic [3:0] head_n;

    always_comb begin
        pop     = KEY_ACK && (cnt_q != 3'd0);
        do_push = accept && ((cnt_q != 3'd4) || pop);
        ovr_n   = accept && (cnt_q == 3'd4) && !pop;
        cnt_n   = cnt_q + 3'(do_push) - 3'(pop);
        rd_n    = rd_q + 2'(pop);
        head_n  = ((cnt_q - 3'(pop)) == 3'd0) ? last_n : fifo_mem[rd_n];
    end

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_q] <= last_n;
    end

    // Outputs mirror the post-update FIFO head, so a push into an empty FIFO shows next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q        <= 2'd0;
            wr_q        <= 2'd0;
            cnt_q       <= 3'd0;
            KEY_VALID   <= 1'b0;
            KEY_CODE    <= 4'd0;
            KEY_OVERRUN <= 1'b0;
        end else begin
            rd_q        <= rd_n;
            wr_q        <= wr_q + 2'(do_push);
            cnt_q       <= cnt_n;
            KEY_VALID   <= (cnt_n != 3'd0);
            KEY_OVERRUN <= ovr_n;
            if (cnt_n != 3'd0) KEY_CODE <= head_n;
        end
    end
`else
    // Single pending key; an ack in the accept cycle makes room for the new key.
    always_ff @(posedge clk) begin
        if (reset) begin
            KEY_VALID   <= 1'b0;
            KEY_CODE    <= 4'd0;
            KEY_OVERRUN <= 1'b0;
        end else begin
            KEY_OVERRUN <= accept && KEY_VALID && !KEY_ACK;
            if (accept && (!KEY_VALID || KEY_ACK)) begin
                KEY_VALID <= 1'b1;
                KEY_CODE  <= last_n;
            end else if (KEY_ACK) begin
                KEY_VALID <= 1'b0;
            end
        end
    end
`endif

endmodule
